shift_mix_seq: RTL and testbench

//  Sequential ShiftRows + MixColumns stage for the AES round datapath.
//  - Accepts a 128-bit state over a valid/ready handshake and applies ShiftRows.
//  - Streams the shifted columns through COLS_PER_CYCLE instances of the 32-bit
//    mix_columns unit, collects the results and presents the mixed state downstream.
//  - Sits between sub_bytes (upstream) and add_round_key (downstream).

---
 rtl/shift_mix_seq.sv | 160 ++++++++++++++++
 tb/tb_shift_mix_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_mix_seq.sv
// shift_mix_seq: ShiftRows on accept, then MixColumns over COLS_PER_CYCLE columns per cycle.
// Optional macro SMS_BYPASS_EN: a last_round state skips MixColumns and goes straight to DONE.
module shift_mix_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state_in,
  input  logic         in_valid,
  output logic         in_ready_o,
  input  logic         last_round,
  output logic [127:0] state_o,
  output logic         out_valid_o,
  input  logic         out_ready,
  output logic         busy_o
);

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_COLS - COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             state;
  fsm_t             state_nxt;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] col_cnt_nxt;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;
  logic [STATE_W-1:0] shifted_in;
  logic [STATE_W-1:0] shifted_q;
  logic             accept;
  logic             bypass_sel;
  logic [COL_W-1:0] lane_res [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column unit: row r enters at [31-8r -: 8], result row r leaves at [8r +: 8]
  function automatic logic [COL_W-1:0] mix_columns(input logic [COL_W-1:0] col);
    logic [7:0]       a [NUM_COLS];
    logic [COL_W-1:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                    ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  // Mix-unit output is LSB-first per row; the state layout is MSB-first
  function automatic logic [COL_W-1:0] byte_swap(input logic [COL_W-1:0] col);
    return {col[7:0], col[15:8], col[23:16], col[31:24]};
  endfunction

  // Byte 4c+r of the result takes byte 4((c+r)%4)+r of the input
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  assign shifted_in = shift_rows(state_in);
  assign accept     = (state == IDLE) && in_valid;

`ifdef SMS_BYPASS_EN
  assign bypass_sel = last_round;
`else
  logic unused_last_round;
  assign bypass_sel        = 1'b0;
  assign unused_last_round = last_round;
`endif

  // One mix_columns lane per column handled in a cycle
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [CNT_W-1:0] col_sel;
    logic [COL_W-1:0] lane_in;
    assign col_sel     = col_cnt + CNT_W'(k);
    assign lane_in     = shifted_q[COL_W*(NUM_COLS-1-32'(col_sel)) +: COL_W];
    assign lane_res[k] = byte_swap(mix_columns(lane_in));
  end

  // State register plus registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      col_cnt     <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_cnt     <= col_cnt_nxt;
      in_ready_o  <= in_ready_nxt;
      out_valid_o <= out_valid_nxt;
      busy_o      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = bypass_sel ? DONE : MIX;
      MIX:     if (col_cnt == LAST_CNT) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    col_cnt_nxt   = '0;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    if (state == MIX) col_cnt_nxt = col_cnt + CNT_STEP;
    unique case (state_nxt)
      IDLE:    in_ready_nxt = 1'b1;
      MIX:     busy_nxt = 1'b1;
      DONE: begin
        busy_nxt      = 1'b1;
        out_valid_nxt = 1'b1;
      end
      default: in_ready_nxt = 1'b1;
    endcase
  end

  // Datapath: shifted state on accept, mixed columns written during MIX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shifted_q <= '0;
      state_o   <= '0;
    end else begin
      if (accept) begin
        shifted_q <= shifted_in;
        if (bypass_sel) state_o <= shifted_in;
      end
      if (state == MIX) begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          state_o[COL_W*(NUM_COLS-1-32'(col_cnt)-k) +: COL_W] <= lane_res[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_mix_seq.sv
// Bench for shift_mix_seq: three instances (1, 2, 4 columns per cycle) driven in lockstep,
// checked against a byte-array AES ShiftRows/MixColumns model.
module tb_shift_mix_seq;

`ifdef SMS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] state_in;
  logic         in_valid;
  logic         last_round;
  logic         out_ready;
  logic         rdy [3];
  logic [127:0] so  [3];
  logic         ov  [3];
  logic         bz  [3];
  int           cpcv [3] = '{1, 2, 4};
  int           n_cmp = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  shift_mix_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .in_valid(in_valid), .in_ready_o(rdy[0]),
    .last_round(last_round), .state_o(so[0]), .out_valid_o(ov[0]), .out_ready(out_ready),
    .busy_o(bz[0]));
  shift_mix_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .in_valid(in_valid), .in_ready_o(rdy[1]),
    .last_round(last_round), .state_o(so[1]), .out_valid_o(ov[1]), .out_ready(out_ready),
    .busy_o(bz[1]));
  shift_mix_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .in_valid(in_valid), .in_ready_o(rdy[2]),
    .last_round(last_round), .state_o(so[2]), .out_valid_o(ov[2]), .out_ready(out_ready),
    .busy_o(bz[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] v, input bit skip_mix);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i%4][i/4] = v[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u[r][c] = skip_mix ? t[r][c] :
                  gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = u[i%4][i/4];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input bit zero_state);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s/rdy%0d", tag, cpcv[d]), 128'(rdy[d]), 128'(1));
      chk($sformatf("%s/ov%0d", tag, cpcv[d]), 128'(ov[d]), 128'(0));
      chk($sformatf("%s/busy%0d", tag, cpcv[d]), 128'(bz[d]), 128'(0));
      if (zero_state) chk($sformatf("%s/state%0d", tag, cpcv[d]), so[d], 128'(0));
    end
  endtask

  // One transaction; nv/nlr are presented with in_valid high while this one is held in DONE
  task automatic run_vec(input string tag, input logic [127:0] v, input logic lr,
                         input logic [127:0] nv, input logic nlr,
                         input bit use_lit, input logic [127:0] lit);
    logic [127:0] exp_s;
    bit           byp;
    int           lat [3];
    int           exp_lat;
    byp   = BYP && lr;
    exp_s = ref_round(v, byp);
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      chk($sformatf("%s/pre_rdy%0d", tag, cpcv[d]), 128'(rdy[d]), 128'(1));
    end
    state_in = v; last_round = lr; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    state_in = nv; last_round = nlr;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      for (int d = 0; d < 3; d++) if (lat[d] == 0 && ov[d] === 1'b1) lat[d] = cyc;
      if (cyc == 1) begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("%s/busy%0d", tag, cpcv[d]), 128'(bz[d]), 128'(1));
          chk($sformatf("%s/rdy_busy%0d", tag, cpcv[d]), 128'(rdy[d]), 128'(0));
        end
      end
      if (cyc < 16) tick();
    end
    for (int d = 0; d < 3; d++) begin
      exp_lat = byp ? 1 : 4 / cpcv[d] + 1;
      chk($sformatf("%s/latency%0d", tag, cpcv[d]), 128'(lat[d]), 128'(exp_lat));
      chk($sformatf("%s/state%0d", tag, cpcv[d]), so[d], exp_s);
      chk($sformatf("%s/ov_held%0d", tag, cpcv[d]), 128'(ov[d]), 128'(1));
      chk($sformatf("%s/rdy_held%0d", tag, cpcv[d]), 128'(rdy[d]), 128'(0));
      if (use_lit) chk($sformatf("%s/literal%0d", tag, cpcv[d]), so[d], lit);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_idle({tag, "/release"}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_in, fips_out, lit, v, nv;
    logic         lr, nlr;
    fips_in  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    fips_out = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    rst_n = 1'b0; in_valid = 1'b1; state_in = fips_in; last_round = 1'b0; out_ready = 1'b1;

    // Reset held three cycles with in_valid high
    tick(); tick(); tick();
    chk_idle("reset", 1'b1);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    // FIPS-197 round 1; the next vector waits with in_valid high under backpressure
    run_vec("fips", fips_in, 1'b0, fips_in, 1'b1, 1'b1, fips_out);
    lit = BYP ? 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5 : fips_out;
    run_vec("last_round", fips_in, 1'b1, 128'hdb135345 << 96, 1'b0, 1'b1, lit);
    in_valid = 1'b0;
    run_vec("single_col", 128'hdb135345 << 96, 1'b0, '0, 1'b0, 1'b0, '0);
    in_valid = 1'b0;

    // Reset during MIX
    state_in = fips_in; last_round = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midmix/ov1_pre", 128'(ov[0]), 128'(0));
    chk("midmix/ov2_pre", 128'(ov[1]), 128'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("midmix", 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midmix/quiet%0d", i), 128'({ov[0], ov[1], ov[2]}), 128'(0));
    end
    run_vec("after_reset", fips_in, 1'b0, '0, 1'b0, 1'b1, fips_out);
    in_valid = 1'b0;

    // Random vectors, chained so each one is offered while the previous is held
    v  = {$urandom, $urandom, $urandom, $urandom};
    lr = 1'($urandom_range(0, 1));
    for (int n = 0; n < 20; n++) begin
      nv  = {$urandom, $urandom, $urandom, $urandom};
      nlr = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", n), v, lr, nv, nlr, 1'b0, '0);
      v  = nv;
      lr = nlr;
    end
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
